// File: rtl/timer_intr_collector.sv
// timer_intr_collector: captures rising edges of the timer's intr line,
// timestamps each against a free-running tick counter and queues the
// timestamps in a small FIFO. Software drains the FIFO over the shared
// addr/rw/din register bus.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   addr, rw, din   register bus (rw = 1 write, rw = 0 read)
//   intr            event input from the countdown timer
//   dout            registered read data, 0 when no read was issued
//   irq             level interrupt: enabled and FIFO non-empty
//   ovf             sticky overflow (event dropped while FIFO full)
//
// DEPTH must be a power of two and at least 2.
module timer_intr_collector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic       rw,
    input  logic [7:0] din,
    input  logic       intr,
    output logic [7:0] dout,
    output logic       irq,
    output logic       ovf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 8;

    localparam logic [7:0] ADDR_CTRL  = 8'h10;
    localparam logic [7:0] ADDR_CMD   = 8'h14;
    localparam logic [7:0] ADDR_HEAD  = 8'h18;
    localparam logic [7:0] ADDR_STAT  = 8'h1C;
    localparam logic [7:0] ADDR_EVCNT = 8'h20;

    logic            en_q, en_d;
    logic            tick_en_q, tick_en_d;
    logic [TS_W-1:0] tick_q, tick_d;
    logic [EW-1:0]   evcnt_q, evcnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            intr_q;
    logic            ovf_q, ovf_d;
    logic [TS_W-1:0] mem_q [DEPTH];
    logic [7:0]      dout_q, dout_d;
    logic            irq_q, irq_d;

    logic            evt;
    logic            wr_ctrl, wr_evcnt, pop_req, clr_req;
    logic            empty, full;
    logic            do_pop, do_push, drop;
    logic [PW-1:0]   occ;
    logic [TS_W-1:0] head;
    logic [7:0]      rdata;

    // only din[1:0] carry meaning for any register
    logic unused_din;
    assign unused_din = ^din[7:2];

    // event detect, FIFO control, register decode and next-state
    always_comb begin
        evt       = intr & ~intr_q;
        wr_ctrl   = rw & (addr == ADDR_CTRL);
        wr_evcnt  = rw & (addr == ADDR_EVCNT);
        pop_req   = rw & (addr == ADDR_CMD) & din[0];
        clr_req   = rw & (addr == ADDR_CMD) & din[1];

        occ       = wptr_q - rptr_q;
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

        // a pop in the same cycle frees a slot, so a full FIFO can still accept
        do_pop    = pop_req & ~empty;
        do_push   = evt & (~full | do_pop);
        drop      = evt & full & ~do_pop;

        en_d      = en_q;
        tick_en_d = tick_en_q;
        if (wr_ctrl) begin
            en_d      = din[0];
            tick_en_d = din[1];
        end

        tick_d = tick_en_q ? (tick_q + TS_W'(1)) : tick_q;

        wptr_d = do_push ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d = do_pop  ? (rptr_q + PW'(1)) : rptr_q;

        // set beats clear
        ovf_d = ovf_q;
        if (clr_req) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;

        // clear first, then count, so clear + event leaves 1
        evcnt_d = wr_evcnt ? '0 : evcnt_q;
        if (evt && (evcnt_d != '1)) evcnt_d = evcnt_d + EW'(1);

        head  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

        rdata = 8'h00;
        case (addr)
            ADDR_CTRL:  rdata = {6'd0, tick_en_q, en_q};
            ADDR_HEAD:  rdata = 8'(head);
            ADDR_STAT:  rdata = {evcnt_q[3:0], ovf_q, 3'(occ)};
            ADDR_EVCNT: rdata = 8'(evcnt_q);
            default:    rdata = 8'h00;
        endcase
        dout_d = rw ? 8'h00 : rdata;

        irq_d  = en_d & (wptr_d != rptr_d);
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            tick_en_q <= 1'b0;
            tick_q    <= '0;
            evcnt_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            intr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dout_q    <= 8'h00;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            en_q      <= en_d;
            tick_en_q <= tick_en_d;
            tick_q    <= tick_d;
            evcnt_q   <= evcnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            intr_q    <= intr;
            ovf_q     <= ovf_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
            // timestamp is the tick value before this cycle's increment
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= tick_q;
            end
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/timer_intr_collector.md
# timer_intr_collector

Downstream companion of the 8-bit countdown timer. Captures the timer's `intr` pulse, timestamps each event against a free-running 8-bit tick counter, and queues timestamps in a 4-entry FIFO. Raises a level interrupt `irq` while the FIFO is non-empty and the collector is enabled. Shares the timer's `addr`/`rw`/`din` register bus and adds a registered read-data path.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of 2, minimum 2.
- `TS_W`, 8: timestamp and tick-counter width.

Ports:
- `clk`: input, 1 bit. Clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous, active-low.
- `addr`: input, 8 bits. Register address, shared with the timer.
- `rw`: input, 1 bit. 1 = write, 0 = read.
- `din`: input, 8 bits. Write data.
- `intr`: input, 1 bit. Event input from the timer.
- `dout`: output, 8 bits. Registered read data.
- `irq`: output, 1 bit. Level interrupt.
- `ovf`: output, 1 bit. Sticky overflow flag.

## Operation
Register map. Any address not listed below is ignored and reads as 0.
- 0x10 CTRL, R/W.
  - bit0 `en`: enables `irq`.
  - bit1 `tick_en`: enables the tick counter.
  - Other bits read 0.
- 0x14 CMD, write-only, reads 0.
  - `din[0]` = 1: pop the FIFO head.
  - `din[1]` = 1: clear `ovf`.
  - Both bits may be set in one write.
- 0x18 HEAD, read-only. Timestamp at the FIFO head; 0 when empty.
- 0x1C STAT, read-only.
  - [2:0] occupancy, 0 to DEPTH.
  - [3] `ovf`.
  - [7:4] low nibble of the event counter.
- 0x20 EVCNT, read-only. Full 8-bit event counter. It saturates at 0xFF and is cleared by a write of any value to 0x20.

Event detect:
- `intr_q` is a 1-cycle registered copy of `intr`.
- `evt = intr & ~intr_q`, i.e. a rising edge only.
- A held-high `intr` counts once.

Tick counter:
- `tick` increments each cycle while `tick_en` = 1, wrapping 0xFF→0x00.
- It holds its value while `tick_en` = 0.

FIFO push (on `evt`):
- Writes the current `tick`, which is the pre-increment value of that cycle.
- The event counter increments (saturating) on every `evt`, including dropped events.
- When full and there is no pop in the same cycle: the event is dropped, `ovf` is set, and FIFO contents are unchanged.

FIFO pop (CMD write with `din[0]`): advances the read pointer; ignored when empty.

Simultaneous push and pop in one cycle:
- Not empty: both are performed and occupancy is unchanged. This includes the full case, which is not an overflow.
- Empty: the push is performed, the pop is ignored, and occupancy becomes 1.

Simultaneous `ovf` set (drop) and `ovf` clear: set wins.

Event counter: a clear write to 0x20 in the same cycle as `evt` leaves the counter at 1.

Outputs:
- `irq = en & (occupancy != 0)`, driven from registered state with no combinational path from the bus.
- `ovf` is the sticky flag directly.

Pointers are `log2(DEPTH)`+1 bits wide. Full is when the MSBs differ and the rest are equal.

## Timing
Reset values (async, immediate):
- `dout` = 0, `irq` = 0, `ovf` = 0.
- CTRL = 0, `tick` = 0, event counter = 0.
- Pointers = 0, `intr_q` = 0, FIFO storage = 0.

Event path:
- `intr` rises before edge N, so `evt` is true for the cycle ending at edge N.
- The push happens at edge N.
- `irq` and STAT reflect the push after edge N (latency 1 cycle from the `intr` rise).

Reads:
- With `rw` = 0 and a mapped address during the cycle before edge N, `dout` holds the data from edge N until the next edge.
- `dout` returns to 0 at the next edge without a read.
- Read data reflects state before edge N's updates.

Writes: take effect at edge N and are visible to a read issued in the following cycle.

Reset assertion mid-operation: all state clears immediately and any pending event is lost.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n` = 0 with `intr` toggling; then release and read 0x1C.
  - Required: `irq` = `ovf` = `dout` = 0 throughout reset; STAT read after release = 0x00.
- **Basic event:**
  - Stimulus: write CTRL = 0x03; pulse `intr` for 1 cycle when `tick` = 0x05.
  - Required: `irq` = 1 one cycle later; HEAD reads 0x05; STAT = 0x11.
  - Then CMD write 0x01: `irq` = 0 the next cycle.
- **Held intr and edge count:**
  - Stimulus: hold `intr` high for 10 cycles, then low; repeat twice.
  - Required: occupancy = 2; EVCNT = 2.
- **Overflow:**
  - Stimulus: 5 events with no pops.
  - Required: occupancy = 4; `ovf` = 1; EVCNT = 5; HEAD = first timestamp.
  - Then CMD write 0x02: `ovf` = 0 and occupancy stays 4.
- **Simultaneous push and pop when full:**
  - Stimulus: pop in the same cycle as `evt` with the FIFO full.
  - Required: occupancy stays 4; `ovf` stays 0; the new timestamp is at the tail (visible after 4 pops).
- **Wrap and saturation:**
  - Stimulus: run the tick counter past 0xFF; generate 300 events with pops.
  - Required: timestamps wrap correctly (e.g. 0xFE, 0x01); EVCNT = 0xFF; write to 0x20 → EVCNT reads 0x00.
